// File: rtl/async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// async_fifo_wr_arb : round-robin burst arbiter for one async FIFO write port
// Rev 1.0
// ============================================================================
module async_fifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int AW   = 4,
  parameter int BL_W = 4,
  parameter int IW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BL_W-1:0] req_len,
  input  logic [NREQ*W-1:0]    req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_done,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 fifo_wr_en,
  output logic [W-1:0]         fifo_wr_data,
  input  logic                 fifo_full,
  input  logic [AW:0]          fifo_free
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [BL_W-1:0] cnt_q, cnt_d;

  logic [IW-1:0]   idx;
  logic [IW-1:0]   pick;
  logic            found;
  logic [BL_W-1:0] pick_len;
  logic            sel_valid;
  logic [W-1:0]    sel_data;
  logic [AW:0]     need;

  // Round-robin search starts just after the last served requester.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    idx       = '0;
    pick_len  = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(rr_q) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*W +: W];
      end
      if (pick == IW'(i)) begin
        pick_len = req_len[i*BL_W +: BL_W];
      end
    end
  end

  assign need = (AW+1)'(cnt_q) + (AW+1)'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    req_ack      = '0;
    req_done     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = pick_len;
          state_d = WAIT;
        end
      end
      // fifo_free can only under-report, so a pass here guarantees room for the burst.
      WAIT: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (fifo_free >= need) begin
          state_d = XFER;
        end
      end
      XFER: begin
        fifo_wr_data = sel_data;
        if (!sel_valid) begin
          state_d = IDLE;
          rr_d    = grant_q;
        end else if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          req_ack    = NREQ'(1) << grant_q;
          if (cnt_q == '0) begin
            req_done = NREQ'(1) << grant_q;
            rr_d     = grant_q;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q - BL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// tb_async_fifo_wr_arb : directed self-checking bench for async_fifo_wr_arb
// Rev 1.0
// ============================================================================
module tb_async_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int AW   = 4;
  localparam int BL_W = 4;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*BL_W-1:0] req_len;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ-1:0]      req_ack;
  logic [NREQ-1:0]      req_done;
  logic [IW-1:0]        grant_id;
  logic                 busy;
  logic                 fifo_wr_en;
  logic [W-1:0]         fifo_wr_data;
  logic                 fifo_full;
  logic [AW:0]          fifo_free;

  async_fifo_wr_arb #(
    .NREQ(NREQ), .W(W), .AW(AW), .BL_W(BL_W), .IW(IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .grant_id     (grant_id),
    .busy         (busy),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_free    (fifo_free)
  );

  always #5 clk = ~clk;

  int              checks   = 0;
  int              failures = 0;
  int              widx     [NREQ];
  int              done_cnt [NREQ];
  bit              hold;
  logic [NREQ-1:0] ack_s;
  logic [NREQ-1:0] done_s;
  logic [NREQ-1:0] ack_exp;

  function automatic logic [W-1:0] dw(int i, int k);
    return 32'hD000_0000 | (32'(i) << 8) | 32'(k);
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = dw(i, widx[i]);
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock: invariant checks at the falling edge, then requester model update after the rising edge.
  task automatic adv();
    @(negedge clk);
    ack_exp = fifo_wr_en ? (NREQ'(1) << grant_id) : '0;
    chk("ack_vs_wr_en", 32'(req_ack), 32'(ack_exp));
    chk("wr_while_full", 32'(fifo_wr_en & fifo_full), 32'(0));
    ack_s  = req_ack;
    done_s = req_done;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_s[i]) widx[i]++;
      if (done_s[i]) begin
        done_cnt[i]++;
        if (!hold) req_valid[i] = 1'b0;
      end
    end
    load_data();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_len   = '0;
    fifo_full = 1'b0;
    fifo_free = 5'd16;
    hold      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      widx[i]     = 0;
      done_cnt[i] = 0;
    end
    load_data();
    #2;
    chk("rst_busy",  32'(busy),         32'(0));
    chk("rst_wr_en", 32'(fifo_wr_en),   32'(0));
    chk("rst_grant", 32'(grant_id),     32'(0));
    chk("rst_ack",   32'(req_ack),      32'(0));
    chk("rst_done",  32'(req_done),     32'(0));
    chk("rst_data",  32'(fifo_wr_data), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: single 4-word burst from requester 0
    do_reset();
    req_len[0 +: BL_W] = 4'd3;
    req_valid = 4'b0001;
    settle();
    chk("t1_c0_busy", 32'(busy), 32'(0));
    chk("t1_c0_wr",   32'(fifo_wr_en), 32'(0));
    adv(); settle();
    chk("t1_c1_busy",  32'(busy), 32'(1));
    chk("t1_c1_wr",    32'(fifo_wr_en), 32'(0));
    chk("t1_c1_grant", 32'(grant_id), 32'(0));
    for (int k = 0; k < 4; k++) begin
      adv(); settle();
      chk("t1_wr",   32'(fifo_wr_en), 32'(1));
      chk("t1_data", fifo_wr_data, dw(0, k));
      chk("t1_done", 32'(req_done), (k == 3) ? 32'(1) : 32'(0));
    end
    adv(); settle();
    chk("t1_c6_busy", 32'(busy), 32'(0));
    chk("t1_c6_wr",   32'(fifo_wr_en), 32'(0));
    chk("t1_done_cnt", 32'(done_cnt[0]), 32'(1));

    // Test 2: all requesters held, single-word bursts, rotation 0,1,2,3,0
    do_reset();
    hold = 1'b1;
    req_valid = 4'b1111;
    adv(); adv();
    for (int b = 0; b < 5; b++) begin
      settle();
      chk("t2_grant", 32'(grant_id), 32'(b % 4));
      chk("t2_wr",    32'(fifo_wr_en), 32'(1));
      chk("t2_ack",   32'(req_ack), 32'(4'b0001 << (b % 4)));
      chk("t2_done",  32'(req_done), 32'(4'b0001 << (b % 4)));
      chk("t2_data",  fifo_wr_data, dw(b % 4, b / 4));
      if (b < 4) begin
        adv(); settle();
        chk("t2_gap_wr", 32'(fifo_wr_en), 32'(0));
        adv(); adv();
      end
    end
    adv();
    req_valid = '0;
    hold = 1'b0;
    settle();
    chk("t2_end_busy", 32'(busy), 32'(0));

    // Test 3: space check boundary, free 2 -> 3 -> 4 for a 4-word burst
    do_reset();
    fifo_free = 5'd2;
    req_len[1*BL_W +: BL_W] = 4'd3;
    req_valid = 4'b0010;
    adv(); settle();
    chk("t3_grant", 32'(grant_id), 32'(1));
    chk("t3_f2_wr", 32'(fifo_wr_en), 32'(0));
    adv(); fifo_free = 5'd3; settle();
    chk("t3_f3_wr",   32'(fifo_wr_en), 32'(0));
    chk("t3_f3_busy", 32'(busy), 32'(1));
    adv(); fifo_free = 5'd4; settle();
    chk("t3_f4_wr", 32'(fifo_wr_en), 32'(0));
    for (int k = 0; k < 4; k++) begin
      adv(); settle();
      chk("t3_wr",   32'(fifo_wr_en), 32'(1));
      chk("t3_data", fifo_wr_data, dw(1, k));
      chk("t3_done", 32'(req_done), (k == 3) ? 32'(2) : 32'(0));
    end

    // Test 4: fifo_full during the second word delays it by one cycle
    do_reset();
    req_len[0 +: BL_W] = 4'd3;
    req_valid = 4'b0001;
    adv(); adv(); settle();
    chk("t4_w0", fifo_wr_data, dw(0, 0));
    adv(); fifo_full = 1'b1; settle();
    chk("t4_full_wr",  32'(fifo_wr_en), 32'(0));
    chk("t4_full_ack", 32'(req_ack), 32'(0));
    chk("t4_full_busy", 32'(busy), 32'(1));
    adv(); fifo_full = 1'b0; settle();
    chk("t4_w1_wr", 32'(fifo_wr_en), 32'(1));
    chk("t4_w1", fifo_wr_data, dw(0, 1));
    adv(); settle();
    chk("t4_w2", fifo_wr_data, dw(0, 2));
    chk("t4_w2_done", 32'(req_done), 32'(0));
    adv(); settle();
    chk("t4_w3", fifo_wr_data, dw(0, 3));
    chk("t4_w3_done", 32'(req_done), 32'(1));
    adv(); settle();
    chk("t4_end_busy", 32'(busy), 32'(0));
    chk("t4_done_cnt", 32'(done_cnt[0]), 32'(1));

    // Test 5: requester 2 withdraws after 2 of 5 words; next grant is requester 3
    do_reset();
    req_len[2*BL_W +: BL_W] = 4'd4;
    req_valid = 4'b0100;
    adv();
    req_valid = 4'b1101;
    settle();
    chk("t5_grant", 32'(grant_id), 32'(2));
    adv(); settle();
    chk("t5_w0",     fifo_wr_data, dw(2, 0));
    chk("t5_w0_ack", 32'(req_ack), 32'(4'b0100));
    adv(); settle();
    chk("t5_w1", fifo_wr_data, dw(2, 1));
    adv(); req_valid[2] = 1'b0; settle();
    chk("t5_abort_wr",   32'(fifo_wr_en), 32'(0));
    chk("t5_abort_done", 32'(req_done), 32'(0));
    adv(); settle();
    chk("t5_idle_busy", 32'(busy), 32'(0));
    adv(); settle();
    chk("t5_next_grant", 32'(grant_id), 32'(3));
    chk("t5_next_busy",  32'(busy), 32'(1));
    adv(); settle();
    chk("t5_r3_data", fifo_wr_data, dw(3, 0));
    chk("t5_r3_done", 32'(req_done), 32'(4'b1000));
    chk("t5_done_cnt2", 32'(done_cnt[2]), 32'(0));

    // Test 6: reset mid-burst, then requester 0 wins with all pending
    do_reset();
    req_len[1*BL_W +: BL_W] = 4'd3;
    req_valid = 4'b0010;
    adv(); adv(); settle();
    chk("t6_w0", fifo_wr_data, dw(1, 0));
    adv(); settle();
    chk("t6_w1", fifo_wr_data, dw(1, 1));
    adv(); reset = 1'b1; settle();
    chk("t6_rst_wr",    32'(fifo_wr_en), 32'(0));
    chk("t6_rst_ack",   32'(req_ack), 32'(0));
    chk("t6_rst_done",  32'(req_done), 32'(0));
    chk("t6_rst_busy",  32'(busy), 32'(0));
    chk("t6_rst_grant", 32'(grant_id), 32'(0));
    chk("t6_rst_data",  32'(fifo_wr_data), 32'(0));
    req_valid = 4'b1111;
    req_len   = '0;
    adv();
    reset = 1'b0;
    adv(); settle();
    chk("t6_post_grant", 32'(grant_id), 32'(0));
    chk("t6_post_busy",  32'(busy), 32'(1));
    chk("t6_done_cnt1",  32'(done_cnt[1]), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
